// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC generator.
// The PC generator and the hazard unit both use these types.
//   pc_state_t : sequencing state of the PC generator (BOOT, RUN)
//   pc_sel_t   : next-PC source chosen by the fixed-priority selector
package pc_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_EXC   = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_HOLD  = 3'd2,
    SEL_CALL  = 3'd3,
    SEL_RET   = 3'd4,
    SEL_SEQ   = 3'd5
  } pc_sel_t;

endpackage : pc_pkg

// File: rtl/pc_ras.sv
// Return-address stack for the fetch PC generator.
// Circular buffer addressed by a top pointer, with an occupancy count.
// A push onto a full stack overwrites the oldest entry and the count stays
// at DEPTH.
//   clk, rst   clock, asynchronous active-high reset
//   push       store push_data as the new top
//   pop        drop the top entry (ignored when empty)
//   replace    overwrite the top entry with push_data, count unchanged
//   clear      empty the stack (highest priority)
//   push_data  return address to store
//   top        current top entry (stale when empty)
//   empty      count == 0
//   full       count == DEPTH
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign top   = mem[top_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (replace) begin
      // Top entry rewritten in the storage block; pointer and count stay.
    end else if (push) begin
      // Pointer wraps onto the oldest slot when full; that entry is lost.
      top_ptr <= top_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - 1'b1;
      count   <= count - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; count==0 masks whatever stale
  // addresses it holds, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (replace)   mem[top_ptr]        <= push_data;
      else if (push) mem[top_ptr + 1'b1] <= push_data;
    end
  end

endmodule : pc_ras

// File: rtl/pc_gen.sv
// Fetch-stage PC generator.
// Holds the fetch PC and offers it to IF via a valid/ready handshake. The
// next PC is chosen by fixed priority: exception, EX redirect, hold (no
// handshake), predicted call, predicted return (via pc_ras), sequential.
//   clk, rst     clock, asynchronous active-high reset
//   i_ready      IF accepts o_pc this cycle
//   exc_req      fetch from EXC_VEC, clear the RAS
//   redir_req    fetch redir_pc, clear the RAS
//   redir_pc     redirect target
//   pred_call    go to pred_target, push o_pc+PC_INC
//   pred_ret     go to the popped return address
//   pred_target  call target
//   o_pc         current fetch PC
//   o_valid      o_pc valid for IF
//   o_ras_miss   one-cycle pulse: return predicted with an empty RAS
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned           ADR_WIDTH = 32,
  parameter logic [ADR_WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [ADR_WIDTH-1:0]  EXC_VEC   = ADR_WIDTH'('h80),
  parameter int unsigned           PC_INC    = 4,
  parameter int unsigned           RAS_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ready,
  input  logic                 exc_req,
  input  logic                 redir_req,
  input  logic [ADR_WIDTH-1:0] redir_pc,
  input  logic                 pred_call,
  input  logic                 pred_ret,
  input  logic [ADR_WIDTH-1:0] pred_target,
  output logic [ADR_WIDTH-1:0] o_pc,
  output logic                 o_valid,
  output logic                 o_ras_miss
);

  pc_state_t              state;
  pc_sel_t                sel;
  logic                   run;
  logic                   fire;
  logic [ADR_WIDTH-1:0]   seq_pc;
  logic [ADR_WIDTH-1:0]   next_pc;
  logic [ADR_WIDTH-1:0]   ras_top;
  logic                   ras_empty;
  logic                   unused_ras_full;

  assign run     = (state == RUN);
  assign o_valid = run;
  assign fire    = o_valid & i_ready;
  // Sequential successor wraps modulo 2^ADR_WIDTH by construction.
  assign seq_pc  = o_pc + ADR_WIDTH'(PC_INC);

  // Exception and redirect outrank the handshake: the pipeline is being
  // flushed, so a stalled IF must not pin the old PC.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = SEL_SEQ;
    if (exc_req)        sel = SEL_EXC;
    else if (redir_req) sel = SEL_REDIR;
    else if (!fire)     sel = SEL_HOLD;
    else if (pred_call) sel = SEL_CALL;
    else if (pred_ret)  sel = SEL_RET;
  end

  always_comb begin
    next_pc = o_pc;
    unique case (sel)
      SEL_EXC:   next_pc = EXC_VEC;
      SEL_REDIR: next_pc = redir_pc;
      SEL_HOLD:  next_pc = o_pc;
      SEL_CALL:  next_pc = pred_target;
      SEL_RET:   next_pc = ras_empty ? seq_pc : ras_top;
      SEL_SEQ:   next_pc = seq_pc;
      default:   next_pc = o_pc;
    endcase
  end

  // Call+return together rewrites the top in place: the callee's return
  // address supersedes the one being returned through.
  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADR_WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (run && sel == SEL_CALL && !pred_ret),
    .pop       (run && sel == SEL_RET && !ras_empty),
    .replace   (run && sel == SEL_CALL && pred_ret),
    .clear     (run && (sel == SEL_EXC || sel == SEL_REDIR)),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (unused_ras_full)
  );

  // NOTE: non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      o_pc       <= RESET_VEC;
      o_ras_miss <= 1'b0;
    end else if (state == BOOT) begin
      // Exceptions/redirects during BOOT are dropped; fetch starts at RESET_VEC.
      state      <= RUN;
      o_pc       <= RESET_VEC;
      o_ras_miss <= 1'b0;
    end else begin
      o_pc       <= next_pc;
      o_ras_miss <= (sel == SEL_RET) && ras_empty;
    end
  end

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen (default parameters: 32-bit, RAS depth 4).
// Directed scenarios followed by random stimulus, all compared against a
// queue-based behavioural model of the next-PC rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ready, exc_req, redir_req, pred_call, pred_ret;
  logic [31:0] redir_pc, pred_target;
  logic [31:0] o_pc;
  logic        o_valid, o_ras_miss;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  bit          m_run;
  bit          m_miss;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .i_ready     (i_ready),
    .exc_req     (exc_req),
    .redir_req   (redir_req),
    .redir_pc    (redir_pc),
    .pred_call   (pred_call),
    .pred_ret    (pred_ret),
    .pred_target (pred_target),
    .o_pc        (o_pc),
    .o_valid     (o_valid),
    .o_ras_miss  (o_ras_miss)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_miss = 0;
    m_pc   = 32'h0;
    m_ras.delete();
  endtask

  // One clock of the spec's next-PC rules, from the current inputs.
  task automatic model_clock();
    logic [31:0] ret_addr;
    if (!m_run) begin
      m_run  = 1;
      m_pc   = 32'h0;
      m_miss = 0;
      return;
    end
    m_miss   = 0;
    ret_addr = m_pc + 32'd4;
    if (exc_req) begin
      m_pc = 32'h80;
      m_ras.delete();
    end else if (redir_req) begin
      m_pc = redir_pc;
      m_ras.delete();
    end else if (!i_ready) begin
      // hold
    end else if (pred_call) begin
      if (pred_ret) begin
        if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ret_addr;
      end else begin
        m_ras.push_back(ret_addr);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc = pred_target;
    end else if (pred_ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc   = ret_addr;
        m_miss = 1;
      end
    end else begin
      m_pc = ret_addr;
    end
  endtask

  task automatic step(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    check({tag, "_pc"},    o_pc,       m_pc);
    check({tag, "_valid"}, 32'(o_valid),    32'(m_run));
    check({tag, "_miss"},  32'(o_ras_miss), 32'(m_miss));
  endtask

  task automatic idle_inputs();
    exc_req = 0; redir_req = 0; pred_call = 0; pred_ret = 0;
    redir_pc = '0; pred_target = '0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redir_req = 1; redir_pc = pc;
    step("redir");
    redir_req = 0;
  endtask

  initial begin
    rst = 1; i_ready = 0;
    idle_inputs();
    model_reset();
    #2;
    check("rst_pc", o_pc, 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_miss", 32'(o_ras_miss), 32'h0);
    @(posedge clk); #1;
    check("rst_hold_pc", o_pc, 32'h0);
    rst = 0;

    // 1: boot then sequential fetch 0,4,8,C,10
    i_ready = 1;
    repeat (5) step("t1");
    check("t1_end", o_pc, 32'h10);

    // 2: stall holds PC, prediction ignored while stalled
    i_ready = 0;
    repeat (3) step("t2_stall");
    pred_call = 1; pred_target = 32'h200;
    step("t2_call_ign");
    check("t2_hold", o_pc, 32'h10);
    pred_call = 0; i_ready = 1;
    redirect(32'h20);

    // 3: call then return
    pred_call = 1; pred_target = 32'h100;
    step("t3_call");
    pred_call = 0;
    step("t3_seq");
    pred_ret = 1;
    step("t3_ret");
    pred_ret = 0;
    check("t3_end", o_pc, 32'h24);

    // 4: overflow the RAS with 5 calls, then 5 returns
    redirect(32'h0);
    for (int k = 0; k < 5; k++) begin
      pred_call = 1; pred_target = 32'h10 * (k + 1);
      step("t4_call");
    end
    pred_call = 0; pred_ret = 1;
    for (int k = 0; k < 4; k++) begin
      step("t4_ret");
      check("t4_ret_addr", o_pc, 32'h44 - 32'h10 * k);
    end
    step("t4_ret_miss");
    check("t4_miss_pc", o_pc, 32'h18);
    check("t4_miss", 32'(o_ras_miss), 32'h1);
    pred_ret = 0;
    step("t4_after");
    check("t4_pulse", 32'(o_ras_miss), 32'h0);

    // 5: exception beats redirect and call, even when stalled; RAS cleared
    pred_call = 1; pred_target = 32'h300;
    step("t5_fill");
    exc_req = 1; redir_req = 1; redir_pc = 32'h400; pred_target = 32'h500;
    i_ready = 0;
    step("t5_exc");
    check("t5_exc_pc", o_pc, 32'h80);
    idle_inputs(); i_ready = 1; pred_ret = 1;
    step("t5_empty");
    check("t5_empty_miss", 32'(o_ras_miss), 32'h1);
    pred_ret = 0;

    // 6: wrap-around and asynchronous reset mid-burst
    redirect(32'hFFFF_FFFC);
    step("t6_wrap");
    check("t6_wrap_pc", o_pc, 32'h0);
    repeat (2) step("t6_burst");
    #2 rst = 1;
    #1;
    check("t6_arst_pc", o_pc, 32'h0);
    check("t6_arst_valid", 32'(o_valid), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    step("t6_boot");
    step("t6_run");

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      i_ready     = ($urandom_range(0, 3) != 0);
      exc_req     = ($urandom_range(0, 31) == 0);
      redir_req   = ($urandom_range(0, 15) == 0);
      redir_pc    = $urandom & 32'hFFFF_FFFC;
      pred_call   = ($urandom_range(0, 3) == 0);
      pred_ret    = ($urandom_range(0, 3) == 0);
      pred_target = $urandom & 32'hFFFF_FFFC;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_gen
